// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative read cache controller: tag compare, true-LRU replacement,
// line refill handshake to the next level, bulk invalidate and hit/miss statistics.
module assoc_cache_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_WORDS = 16,
  parameter int unsigned SETS       = 32,
  parameter int unsigned WAYS       = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     resp_valid,
  output logic [31:0]              resp_data,
  output logic                     resp_hit,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [ADDR_W-1:0]        mem_req_addr,
  input  logic                     mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_resp_data,
  input  logic                     flush,
  output logic                     busy,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);
  localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned LINE_W = 32 * LINE_WORDS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_REQ,
    ST_MISS_WAIT,
    ST_FLUSH
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-3:0]   addr_q, addr_d;
  logic [WAY_W-1:0]    victim_q, victim_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_hit_q, resp_hit_d;
  logic [31:0]         resp_data_q, resp_data_d;
  logic                mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0]   mem_req_addr_q, mem_req_addr_d;
  logic [31:0]         hit_cnt_q, hit_cnt_d;
  logic [31:0]         miss_cnt_q, miss_cnt_d;
  logic                flush_pend_q, flush_pend_d;
  logic [IDX_W-1:0]    flush_idx_q, flush_idx_d;
  logic                flush_prev_q;

  logic [LINE_W-1:0]   data_q  [WAYS][SETS];
  logic [TAG_W-1:0]    tag_q   [WAYS][SETS];
  logic [SETS-1:0]     valid_q [WAYS];
  logic [WAY_W-1:0]    age_q   [WAYS][SETS];

  logic [OFF_W-1:0]    word_c;
  logic [IDX_W-1:0]    idx_c;
  logic [TAG_W-1:0]    tag_c;
  logic                hit_c;
  logic [WAY_W-1:0]    hit_way_c;
  logic [WAY_W-1:0]    victim_c;
  logic [WAY_W-1:0]    max_age_c;
  logic                found_inv_c;
  logic                fill_en, lru_en, clr_en;
  logic [WAY_W-1:0]    lru_way;
  logic                unused_ok;

  assign unused_ok = ^req_addr[1:0];

  assign word_c = addr_q[OFF_W-1:0];
  assign idx_c  = addr_q[OFF_W +: IDX_W];
  assign tag_c  = addr_q[ADDR_W-3 -: TAG_W];

  assign req_ready     = (state_q == ST_IDLE) && !flush_pend_q && !flush;
  assign busy          = (state_q != ST_IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_hit      = resp_hit_q;
  assign resp_data     = resp_data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;

  // Word 0 sits in the MSBs of a line.
  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                            input logic [OFF_W-1:0]  k);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (k == OFF_W'(i)) w = line[32*(LINE_WORDS-1-i) +: 32];
    end
    return w;
  endfunction

  // Tag compare across the ways of the looked-up set.
  always_comb begin
    hit_c     = 1'b0;
    hit_way_c = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_c && valid_q[w][idx_c] && (tag_q[w][idx_c] == tag_c)) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise the oldest way.
  always_comb begin
    found_inv_c = 1'b0;
    victim_c    = '0;
    max_age_c   = age_q[0][idx_c];
    for (int w = 0; w < WAYS; w++) begin
      if (!found_inv_c && !valid_q[w][idx_c]) begin
        found_inv_c = 1'b1;
        victim_c    = WAY_W'(w);
      end
    end
    if (!found_inv_c) begin
      for (int w = 1; w < WAYS; w++) begin
        if (age_q[w][idx_c] > max_age_c) begin
          max_age_c = age_q[w][idx_c];
          victim_c  = WAY_W'(w);
        end
      end
    end
  end

  // Next-state and datapath controls.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    victim_d        = victim_q;
    resp_valid_d    = 1'b0;
    resp_hit_d      = resp_hit_q;
    resp_data_d     = resp_data_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;
    flush_pend_d    = flush_pend_q | (flush && !flush_prev_q && (state_q != ST_IDLE));
    flush_idx_d     = flush_idx_q;
    fill_en         = 1'b0;
    lru_en          = 1'b0;
    clr_en          = 1'b0;
    lru_way         = '0;

    case (state_q)
      ST_IDLE: begin
        if (flush || flush_pend_q) begin
          state_d     = ST_FLUSH;
          flush_idx_d = '0;
        end else if (req_valid) begin
          addr_d  = req_addr[ADDR_W-1:2];
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit_c) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
          resp_data_d  = line_word(data_q[hit_way_c][idx_c], word_c);
          lru_en       = 1'b1;
          lru_way      = hit_way_c;
          if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
          state_d      = ST_IDLE;
        end else begin
          if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
          victim_d        = victim_c;
          mem_req_valid_d = 1'b1;
          mem_req_addr_d  = {tag_c, idx_c, {(OFF_W+2){1'b0}}};
          state_d         = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        if (mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = ST_MISS_WAIT;
        end
      end
      ST_MISS_WAIT: begin
        if (mem_resp_valid) begin
          fill_en      = 1'b1;
          lru_en       = 1'b1;
          lru_way      = victim_q;
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b0;
          resp_data_d  = line_word(mem_resp_data, word_c);
          state_d      = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        clr_en = 1'b1;
        if (flush_idx_q == IDX_W'(SETS-1)) begin
          flush_pend_d = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          flush_idx_d = flush_idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q          <= '0;
      victim_q        <= '0;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_data_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
      flush_pend_q    <= 1'b0;
      flush_idx_q     <= '0;
      flush_prev_q    <= 1'b0;
    end else begin
      addr_q          <= addr_d;
      victim_q        <= victim_d;
      resp_valid_q    <= resp_valid_d;
      resp_hit_q      <= resp_hit_d;
      resp_data_q     <= resp_data_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      hit_cnt_q       <= hit_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
      flush_pend_q    <= flush_pend_d;
      flush_idx_q     <= flush_idx_d;
      flush_prev_q    <= flush;
    end
  end

  // Valid bits and LRU ages; flush walks one set per cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        for (int s = 0; s < SETS; s++) age_q[w][s] <= WAY_W'(w);
      end
    end else if (clr_en) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w][flush_idx_q] <= 1'b0;
        age_q[w][flush_idx_q]   <= WAY_W'(w);
      end
    end else begin
      if (fill_en) valid_q[victim_q][idx_c] <= 1'b1;
      if (lru_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == lru_way)
            age_q[w][idx_c] <= '0;
          else if (age_q[w][idx_c] < age_q[lru_way][idx_c])
            age_q[w][idx_c] <= age_q[w][idx_c] + WAY_W'(1);
        end
      end
    end
  end

  // Line data and tags are never reset or flushed; valid bits gate them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      data_q[victim_q][idx_c] <= mem_resp_data;
      tag_q[victim_q][idx_c]  <= tag_c;
    end
  end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Self-checking bench for assoc_cache_ctrl: scripted reads against a memory model,
// responses checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_assoc_cache_ctrl;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned LINE_WORDS = 16;
  localparam int unsigned SETS       = 32;
  localparam int unsigned WAYS       = 2;
  localparam int unsigned LINE_W     = 32 * LINE_WORDS;
  localparam logic [31:0] LINE_MASK  = ~32'(LINE_WORDS*4 - 1);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_hit;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid = 1'b0;
  logic [LINE_W-1:0] mem_resp_data = '0;
  logic              flush = 1'b0;
  logic              busy;
  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  assoc_cache_ctrl #(
    .ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS), .SETS(SETS), .WAYS(WAYS)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .flush(flush), .busy(busy), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        hit;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_hits = 0;
  int   exp_misses = 0;

  // Memory contents: word at byte address a is 0xFF0 + a/4 (line 0x40 -> 0x1000+k).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0000_0FF0 + (a >> 2);
  endfunction

  function automatic logic [LINE_W-1:0] mem_line(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    logic [31:0]       base;
    base = a & LINE_MASK;
    l    = '0;
    for (int k = 0; k < LINE_WORDS; k++)
      l[32*(LINE_WORDS-1-k) +: 32] = mem_word(base + 32'(4*k));
    return l;
  endfunction

  // Scoreboard: every response pulse must match the oldest outstanding expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (reset && resp_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp: got data=%h hit=%b, required no response", resp_data, resp_hit);
      end else begin
        mon_e = sb.pop_front();
        if (resp_data !== mon_e.data || resp_hit !== mon_e.hit) begin
          errors++;
          $display("FAIL resp_payload: got data=%h hit=%b, required data=%h hit=%b",
                   resp_data, resp_hit, mon_e.data, mon_e.hit);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: normal, 1: pulse flush in MISS_WAIT, 2: reset in MISS_WAIT
  task automatic do_read(input logic [31:0] addr, input bit exp_hit, input int hold, input int mode);
    int          n;
    logic [31:0] held;
    exp_t        e;
    req_addr  = addr;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout: addr=%h req_ready=%b, required 1", addr, req_ready);
      req_valid = 1'b0;
      return;
    end
    tick();
    req_valid = 1'b0;
    e.data = mem_word(addr & ~32'h3);
    e.hit  = exp_hit;
    sb.push_back(e);
    if (exp_hit) exp_hits++;
    else         exp_misses++;
    tick();
    if (exp_hit) begin
      checks++;
      if (resp_valid !== 1'b1 || mem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL hit_latency: addr=%h resp_valid=%b mem_req_valid=%b, required 1/0",
                 addr, resp_valid, mem_req_valid);
      end
      return;
    end
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== (addr & LINE_MASK)) begin
      errors++;
      $display("FAIL miss_req: addr=%h mem_req_valid=%b mem_req_addr=%h, required 1/%h",
               addr, mem_req_valid, mem_req_addr, addr & LINE_MASK);
    end
    held = mem_req_addr;
    for (int i = 0; i < hold; i++) begin
      tick();
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== held) begin
        errors++;
        $display("FAIL req_stable: cycle %0d mem_req_valid=%b addr=%h, required 1/%h",
                 i, mem_req_valid, mem_req_addr, held);
      end
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    checks++;
    if (mem_req_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL req_drop: mem_req_valid=%b busy=%b, required 0/1", mem_req_valid, busy);
    end
    if (mode == 1) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    if (mode == 2) begin
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_data !== 32'h0 ||
          mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 || busy !== 1'b0 ||
          hit_count !== 32'h0 || miss_count !== 32'h0) begin
        errors++;
        $display("FAIL reset_midflight: rv=%b rh=%b rd=%h mrv=%b mra=%h busy=%b hc=%0d mc=%0d, required all 0",
                 resp_valid, resp_hit, resp_data, mem_req_valid, mem_req_addr, busy, hit_count, miss_count);
      end
      sb.delete();
      exp_hits   = 0;
      exp_misses = 0;
      tick();
      tick();
      reset = 1'b1;
      mem_resp_data  = mem_line(addr);
      mem_resp_valid = 1'b1;
      tick();
      mem_resp_valid = 1'b0;
      tick();
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL late_resp: resp_valid=%b busy=%b, required 0/0", resp_valid, busy);
      end
      return;
    end
    tick();
    mem_resp_data  = mem_line(addr);
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    checks++;
    if (resp_valid !== 1'b1 || resp_hit !== 1'b0) begin
      errors++;
      $display("FAIL refill_resp: addr=%h resp_valid=%b resp_hit=%b, required 1/0",
               addr, resp_valid, resp_hit);
    end
  endtask

  task automatic check_counters(input string name);
    checks++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
      errors++;
      $display("FAIL counters_%s: hit=%0d miss=%0d, required hit=%0d miss=%0d",
               name, hit_count, miss_count, exp_hits, exp_misses);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_data !== 32'h0 || mem_req_valid !== 1'b0 ||
        mem_req_addr !== 32'h0 || busy !== 1'b0 || hit_count !== 32'h0 || miss_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: rv=%b rh=%b rd=%h mrv=%b mra=%h busy=%b, required all 0",
               resp_valid, resp_hit, resp_data, mem_req_valid, mem_req_addr, busy);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b busy=%b, required 1/0", req_ready, busy);
    end
  endtask

  task automatic test_miss_refill();
    do_read(32'h44, 1'b0, 0, 0);
    check_counters("miss_refill");
  endtask

  task automatic test_hit();
    do_read(32'h48, 1'b1, 0, 0);
    check_counters("hit");
  endtask

  task automatic test_lru();
    do_read(32'h040,  1'b1, 0, 0);
    do_read(32'h840,  1'b0, 5, 0);
    do_read(32'h040,  1'b1, 0, 0);
    do_read(32'h1040, 1'b0, 0, 0);
    do_read(32'h040,  1'b1, 0, 0);
    do_read(32'h840,  1'b0, 5, 0);
    do_read(32'h1040, 1'b0, 0, 0);
    check_counters("lru");
  endtask

  task automatic test_flush();
    do_read(32'h080, 1'b0, 0, 1);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_pending_ready: req_ready=%b, required 0", req_ready);
    end
    for (int i = 0; i < SETS; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL flush_busy: cycle %0d busy=%b req_ready=%b, required 1/0", i, busy, req_ready);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_done: busy=%b req_ready=%b, required 0/1", busy, req_ready);
    end
    do_read(32'h040, 1'b0, 0, 0);
    do_read(32'h080, 1'b0, 0, 0);
    check_counters("flush");
  endtask

  task automatic test_stray_resp();
    mem_resp_data  = {LINE_WORDS{32'hDEAD_BEEF}};
    mem_resp_valid = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_resp: busy=%b resp_valid=%b, required 0/0", busy, resp_valid);
    end
    do_read(32'h044, 1'b1, 0, 0);
    do_read(32'h08C, 1'b1, 0, 0);
    check_counters("stray");
  endtask

  task automatic test_back_to_back();
    do_read(32'h040, 1'b1, 0, 0);
    do_read(32'h07C, 1'b1, 0, 0);
    do_read(32'h084, 1'b1, 0, 0);
    check_counters("b2b");
  endtask

  task automatic test_reset_midflight();
    do_read(32'h0C0, 1'b0, 0, 2);
    do_read(32'h040, 1'b0, 0, 0);
    do_read(32'h0C0, 1'b0, 0, 0);
    check_counters("reset_midflight");
  endtask

  initial begin
    test_reset();
    test_miss_refill();
    test_hit();
    test_lru();
    test_flush();
    test_stray_resp();
    test_back_to_back();
    test_reset_midflight();
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drained: %0d responses outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
